// File: rtl/mux_rr_arbiter.sv
// Two-requester round-robin packet arbiter in front of a shared 2:1 data mux with a registered output stage.
// Optional grant statistics counters are enabled by defining MUX_ARB_STATS_EN.
`timescale 1ns/1ps

module mux_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic [1:0]       In_Valid,
    output logic [1:0]       In_Ready,
    input  logic [1:0]       In_Last,
    input  logic [WIDTH-1:0] In_Data0,
    input  logic [WIDTH-1:0] In_Data1,
    output logic [1:0]       Gnt,
    output logic             Select_Line,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [WIDTH-1:0] Out_Data,
    output logic             Out_Last
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]      Gnt_Count0,
    output logic [15:0]      Gnt_Count1
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_ptr;
    logic             r_sel;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_data;

    logic             w_out_free;
    logic             w_pick;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_last;

    // The output register can take a new beat when it is empty or being drained this cycle.
    assign w_out_free  = !r_out_valid || Out_Ready;
    assign Gnt         = {r_state == GRANT1, r_state == GRANT0};
    assign In_Ready    = Gnt & {2{w_out_free}};
    assign w_accept    = |(In_Valid & In_Ready);

    // On a tie the pointer decides; otherwise the single active requester wins.
    assign w_pick      = (In_Valid == 2'b11) ? r_ptr : In_Valid[1];

    assign w_mux_data  = r_sel ? In_Data1 : In_Data0;
    assign w_mux_last  = In_Last[r_sel];

    assign Select_Line = r_sel;
    assign Out_Valid   = r_out_valid;
    assign Out_Data    = r_out_data;
    assign Out_Last    = r_out_last;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|In_Valid) begin
                        r_state <= w_pick ? GRANT1 : GRANT0;
                        r_sel   <= w_pick;
                    end
                end
                GRANT0, GRANT1: begin
                    // The grant is released only by an accepted Last beat, never by a stalled requester.
                    if (w_accept && w_mux_last) begin
                        r_state <= IDLE;
                        r_ptr   <= ~r_sel;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_mux_data;
                r_out_last  <= w_mux_last;
            end else if (Out_Ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef MUX_ARB_STATS_EN
    logic [15:0] r_gnt_count0;
    logic [15:0] r_gnt_count1;

    // Counts IDLE->GRANTi transitions, saturating at all-ones.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_gnt_count0 <= '0;
            r_gnt_count1 <= '0;
        end else if (r_state == IDLE && |In_Valid) begin
            if (!w_pick && r_gnt_count0 != 16'hFFFF) r_gnt_count0 <= r_gnt_count0 + 16'd1;
            if (w_pick && r_gnt_count1 != 16'hFFFF)  r_gnt_count1 <= r_gnt_count1 + 16'd1;
        end
    end

    assign Gnt_Count0 = r_gnt_count0;
    assign Gnt_Count1 = r_gnt_count1;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: arbitration vector table, scoreboarded packet streams and
// hand-written reset, backpressure and stall sequences (stats checks when MUX_ARB_STATS_EN is defined).
`timescale 1ns/1ps

module tb_mux_rr_arbiter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } beat_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic [1:0] valid;
        logic       out_ready;
        logic [1:0] exp_gnt;
        logic       exp_sel;
        logic [1:0] exp_in_ready;
    } vec_t;

    logic       Clock    = 1'b0;
    logic       Reset_n  = 1'b0;
    logic [1:0] tb_valid = 2'b00;
    logic [1:0] tb_last  = 2'b00;
    logic [7:0] tb_d0    = 8'h00;
    logic [7:0] tb_d1    = 8'h00;
    logic       tb_out_ready = 1'b0;

    logic [1:0] In_Ready;
    logic [1:0] Gnt;
    logic       Select_Line;
    logic       Out_Valid;
    logic [7:0] Out_Data;
    logic       Out_Last;
`ifdef MUX_ARB_STATS_EN
    logic [15:0] Gnt_Count0;
    logic [15:0] Gnt_Count1;
`endif

    mux_rr_arbiter #(.WIDTH(8)) dut (
        .Clock       (Clock),
        .Reset_n     (Reset_n),
        .In_Valid    (tb_valid),
        .In_Ready    (In_Ready),
        .In_Last     (tb_last),
        .In_Data0    (tb_d0),
        .In_Data1    (tb_d1),
        .Gnt         (Gnt),
        .Select_Line (Select_Line),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (tb_out_ready),
        .Out_Data    (Out_Data),
        .Out_Last    (Out_Last)
`ifdef MUX_ARB_STATS_EN
        ,
        .Gnt_Count0  (Gnt_Count0),
        .Gnt_Count1  (Gnt_Count1)
`endif
    );

    always #5 Clock = ~Clock;

    int         n_tests = 0;
    int         n_fail  = 0;
    bit         sb_en    = 1'b0;
    bit         trace_en = 1'b0;
    exp_t       expq[$];
    logic [7:0] seen[$];
    logic [7:0] exp_seq[$];
    logic [1:0] gtrace[$];
    beat_t      plan0[$];
    beat_t      plan1[$];
    vec_t       vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        sb_en        = 1'b0;
        Reset_n      = 1'b0;
        tb_valid     = 2'b00;
        tb_last      = 2'b00;
        tb_out_ready = 1'b0;
        repeat (2) tick();
        Reset_n = 1'b1;
        tick();
        expq.delete();
        seen.delete();
    endtask

    // Output-side scoreboard and grant trace, sampled on the falling edge.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge Clock);
            if (trace_en) gtrace.push_back(Gnt);
            if (sb_en && Reset_n && Out_Valid && tb_out_ready) begin
                if (expq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %0h expected none", Out_Data);
                end else begin
                    e = expq.pop_front();
                    check("sb_data", Out_Data, e.data);
                    check("sb_last", Out_Last, e.last);
                end
                seen.push_back(Out_Data);
            end
        end
    endtask

    // Drives one requester's plan; each beat is held until the arbiter takes it.
    task automatic drive(input int id);
        beat_t b;
        int    n;
        int    waited;
        bit    accepted;
        n = (id != 0) ? plan1.size() : plan0.size();
        for (int k = 0; k < n; k++) begin
            b = (id != 0) ? plan1[k] : plan0[k];
            for (int g = 0; g < int'(b.gap); g++) begin
                tb_valid[id] = 1'b0;
                tick();
            end
            tb_valid[id] = 1'b1;
            tb_last[id]  = b.last;
            if (id != 0) tb_d1 = b.data;
            else         tb_d0 = b.data;
            waited   = 0;
            accepted = 1'b0;
            while (!accepted && waited < 200) begin
                @(negedge Clock);
                if (In_Ready[id] && Reset_n) begin
                    accepted = 1'b1;
                    expq.push_back('{data: b.data, last: b.last});
                end
                tick();
                waited++;
            end
            if (!accepted) begin
                n_tests++;
                n_fail++;
                $display("FAIL accept_timeout: requester %0d beat %0h not accepted, required accept", id, b.data);
                break;
            end
        end
        tb_valid[id] = 1'b0;
        tb_last[id]  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (expq.size() != 0 && w < 50) begin
            tick();
            w++;
        end
        tick();
        check("drain_empty", expq.size(), 0);
    endtask

    task automatic check_seen(input string name);
        check({name, "_count"}, seen.size(), exp_seq.size());
        for (int i = 0; i < exp_seq.size(); i++)
            check(name, (i < seen.size()) ? {24'h0, seen[i]} : 32'hxxxx_xxxx, {24'h0, exp_seq[i]});
    endtask

    initial begin
        logic [1:0] exp_trace[13];

        fork
            monitor();
        join_none

        // Arbitration out of IDLE right after reset (pointer = 0).
        vecs[0] = '{valid: 2'b00, out_ready: 1'b1, exp_gnt: 2'b00, exp_sel: 1'b0, exp_in_ready: 2'b00};
        vecs[1] = '{valid: 2'b01, out_ready: 1'b1, exp_gnt: 2'b01, exp_sel: 1'b0, exp_in_ready: 2'b01};
        vecs[2] = '{valid: 2'b10, out_ready: 1'b1, exp_gnt: 2'b10, exp_sel: 1'b1, exp_in_ready: 2'b10};
        vecs[3] = '{valid: 2'b11, out_ready: 1'b1, exp_gnt: 2'b01, exp_sel: 1'b0, exp_in_ready: 2'b01};
        vecs[4] = '{valid: 2'b10, out_ready: 1'b0, exp_gnt: 2'b10, exp_sel: 1'b1, exp_in_ready: 2'b10};

        do_reset();
        check("rst_gnt", Gnt, 2'b00);
        check("rst_sel", Select_Line, 1'b0);
        check("rst_in_ready", In_Ready, 2'b00);
        check("rst_out_valid", Out_Valid, 1'b0);
        check("rst_out_data", Out_Data, 8'h00);
        check("rst_out_last", Out_Last, 1'b0);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            tb_d0        = 8'h5A;
            tb_d1        = 8'hA5;
            tb_last      = 2'b00;
            tb_valid     = vecs[i].valid;
            tb_out_ready = vecs[i].out_ready;
            tick();
            check("vec_gnt", Gnt, vecs[i].exp_gnt);
            check("vec_sel", Select_Line, vecs[i].exp_sel);
            check("vec_in_ready", In_Ready, vecs[i].exp_in_ready);
            check("vec_out_valid", Out_Valid, 1'b0);
        end

        // Single requester, three-beat packet.
        do_reset();
        sb_en = 1'b1;
        tb_out_ready = 1'b1;
        plan0 = '{'{data: 8'hA1, last: 1'b0, gap: 8'd0},
                  '{data: 8'hA2, last: 1'b0, gap: 8'd0},
                  '{data: 8'hA3, last: 1'b1, gap: 8'd0}};
        fork
            drive(0);
            begin
                @(negedge Clock);
                check("single_gnt_n", Gnt, 2'b00);
                tick();
                @(negedge Clock);
                check("single_gnt_n1", Gnt, 2'b01);
                check("single_sel_n1", Select_Line, 1'b0);
                check("single_rdy_n1", In_Ready, 2'b01);
            end
        join
        check("single_gnt_after", Gnt, 2'b00);
        drain();
        exp_seq = '{8'hA1, 8'hA2, 8'hA3};
        check_seen("single_seq");

        // Tie and alternation with one bubble between packets.
        do_reset();
        sb_en = 1'b1;
        tb_out_ready = 1'b1;
        plan0 = '{'{data: 8'h01, last: 1'b0, gap: 8'd0}, '{data: 8'h02, last: 1'b1, gap: 8'd0},
                  '{data: 8'h03, last: 1'b0, gap: 8'd0}, '{data: 8'h04, last: 1'b1, gap: 8'd0}};
        plan1 = '{'{data: 8'h11, last: 1'b0, gap: 8'd0}, '{data: 8'h12, last: 1'b1, gap: 8'd0},
                  '{data: 8'h13, last: 1'b0, gap: 8'd0}, '{data: 8'h14, last: 1'b1, gap: 8'd0}};
        gtrace.delete();
        trace_en = 1'b1;
        fork
            drive(0);
            drive(1);
        join
        drain();
        trace_en = 1'b0;
        exp_trace = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                      2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        for (int i = 0; i < 13; i++)
            check("tie_gnt_trace", (i < gtrace.size()) ? {30'h0, gtrace[i]} : 32'hxxxx_xxxx,
                  {30'h0, exp_trace[i]});
        exp_seq = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h03, 8'h04, 8'h13, 8'h14};
        check_seen("tie_seq");

        // Backpressure: Out_Ready low for 4 cycles while B2 sits in the output register.
        do_reset();
        sb_en = 1'b1;
        plan0 = '{'{data: 8'hB1, last: 1'b0, gap: 8'd0}, '{data: 8'hB2, last: 1'b0, gap: 8'd0},
                  '{data: 8'hB3, last: 1'b0, gap: 8'd0}, '{data: 8'hB4, last: 1'b1, gap: 8'd0}};
        plan1.delete();
        fork
            drive(0);
            begin
                tb_out_ready = 1'b1;
                repeat (3) tick();
                tb_out_ready = 1'b0;
                for (int c = 0; c < 4; c++) begin
                    @(negedge Clock);
                    check("bp_valid", Out_Valid, 1'b1);
                    check("bp_data", Out_Data, 8'hB2);
                    check("bp_last", Out_Last, 1'b0);
                    check("bp_in_ready", In_Ready, 2'b00);
                    tick();
                end
                tb_out_ready = 1'b1;
            end
        join
        drain();
        exp_seq = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        check_seen("bp_seq");

        // Requester 1 stalls mid-packet; requester 0 must wait for its Last.
        do_reset();
        sb_en = 1'b1;
        tb_out_ready = 1'b1;
        plan1 = '{'{data: 8'hC1, last: 1'b0, gap: 8'd0}, '{data: 8'hC2, last: 1'b1, gap: 8'd5}};
        plan0 = '{'{data: 8'hD1, last: 1'b1, gap: 8'd1}};
        fork
            drive(0);
            drive(1);
            begin
                repeat (2) tick();
                for (int c = 0; c < 5; c++) begin
                    @(negedge Clock);
                    check("stall_gnt", Gnt, 2'b10);
                    check("stall_rdy0", In_Ready[0], 1'b0);
                    tick();
                end
            end
        join
        drain();
        exp_seq = '{8'hC1, 8'hC2, 8'hD1};
        check_seen("stall_seq");

        // Asynchronous reset with a beat pending on the output.
        do_reset();
        tb_d1        = 8'hE1;
        tb_last      = 2'b00;
        tb_valid     = 2'b10;
        tb_out_ready = 1'b0;
        repeat (2) tick();
        check("arst_pre_valid", Out_Valid, 1'b1);
        check("arst_pre_sel", Select_Line, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check("arst_valid", Out_Valid, 1'b0);
        check("arst_gnt", Gnt, 2'b00);
        check("arst_sel", Select_Line, 1'b0);
        check("arst_data", Out_Data, 8'h00);
        check("arst_in_ready", In_Ready, 2'b00);
        tb_valid = 2'b00;
        tick();
        Reset_n = 1'b1;
        tick();
        check("arst_idle_gnt", Gnt, 2'b00);
        check("arst_idle_valid", Out_Valid, 1'b0);

`ifdef MUX_ARB_STATS_EN
        do_reset();
        tb_out_ready = 1'b1;
        tb_last      = 2'b11;
        tb_valid     = 2'b01;
        repeat (6) tick();
        tb_valid = 2'b10;
        repeat (4) tick();
        tb_valid = 2'b00;
        repeat (2) tick();
        check("stats_cnt0", Gnt_Count0, 16'd3);
        check("stats_cnt1", Gnt_Count1, 16'd2);
        tb_valid = 2'b01;
        repeat (2 * 65540) tick();
        tb_valid = 2'b00;
        repeat (2) tick();
        check("stats_sat0", Gnt_Count0, 16'hFFFF);
        check("stats_hold1", Gnt_Count1, 16'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
